seqmul_accumulator: RTL and testbench

Downstream consumer of the 8x8 shift-add sequential multiplier. It captures each 16-bit product on the multiplier's done pulse and sums a programmable-length frame of 1 to 16 products into a 20-bit accumulator. It presents the frame sum on a valid/ready output port. It also drives a busy flag so the upstream controller can hold off `start` while a result is waiting to be taken.

---
 rtl/seqmul_accumulator.sv | 102 ++++++++++
 tb/tb_seqmul_accumulator.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seqmul_accumulator.sv
// rtl/seqmul_accumulator.sv - frame accumulator for sequential multiplier products with valid/ready result port
module seqmul_accumulator #(
    parameter int PROD_W = 16,
    parameter int LEN_W  = 4,
    localparam int ACC_W = PROD_W + LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [LEN_W-1:0]  len,
    input  logic              mul_done,
    input  logic [PROD_W-1:0] mul_prod,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [ACC_W-1:0]  acc_out,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [ACC_W-1:0]   acc, acc_d;
    logic [LEN_W-1:0]   cnt, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_inc;
    logic               overrun_d;
    logic               take_first;

    assign cnt_inc = cnt + LEN_W'(1);

    // State and datapath registers; reset discards any partial frame at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            len_q   <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_d;
            acc     <= acc_d;
            cnt     <= cnt_d;
            len_q   <= len_d;
            overrun <= overrun_d;
        end
    end

    // Next-state and datapath update; clear overrides everything, including a same-cycle product
    always_comb begin
        state_d    = state;
        acc_d      = acc;
        cnt_d      = cnt;
        len_d      = len_q;
        overrun_d  = overrun;
        take_first = 1'b0;
        if (clear) begin
            state_d   = IDLE;
            acc_d     = '0;
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_done) take_first = 1'b1;
                end
                ACCUM: begin
                    if (mul_done) begin
                        acc_d = acc + ACC_W'(mul_prod);
                        cnt_d = cnt_inc;
                        if (cnt_inc == len_q) state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        // A product arriving on the handshake edge opens the next frame
                        if (mul_done) take_first = 1'b1;
                    end else if (mul_done) begin
                        overrun_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (take_first) begin
                acc_d   = ACC_W'(mul_prod);
                len_d   = len;
                cnt_d   = '0;
                state_d = (len == '0) ? HOLD : ACCUM;
            end
        end
    end

    assign out_valid = (state == HOLD);
    assign busy      = (state == HOLD);
    assign acc_out   = acc;

endmodule

// File: tb/tb_seqmul_accumulator.sv
// tb/tb_seqmul_accumulator.sv - self-checking bench for seqmul_accumulator
module tb_seqmul_accumulator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [3:0]  len = 4'd0;
    logic        mul_done = 1'b0;
    logic [15:0] mul_prod = 16'd0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [19:0] acc_out;
    logic        busy;
    logic        overrun;

    int errors = 0;
    int checks = 0;

    // Reference model: frame bookkeeping in plain integers
    bit          m_hold;
    bit          m_in_frame;
    int unsigned m_taken;
    int unsigned m_target;
    int unsigned m_sum;
    bit          m_ovr;

    seqmul_accumulator #(.PROD_W(16), .LEN_W(4)) dut (
        .clk(clk), .reset(reset), .clear(clear), .len(len),
        .mul_done(mul_done), .mul_prod(mul_prod), .out_ready(out_ready),
        .out_valid(out_valid), .acc_out(acc_out), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_hold = 0; m_in_frame = 0; m_taken = 0; m_target = 0; m_sum = 0; m_ovr = 0;
    endtask

    task automatic model_start(input int unsigned p, input int unsigned l);
        m_sum = p; m_taken = 1; m_target = l + 1;
        if (m_target == 1) begin m_hold = 1; m_in_frame = 0; end
        else begin m_hold = 0; m_in_frame = 1; end
    endtask

    task automatic model_step(input bit c, input bit md, input int unsigned p, input int unsigned l, input bit r);
        if (c) begin
            m_hold = 0; m_in_frame = 0; m_sum = 0; m_taken = 0; m_ovr = 0;
        end else if (m_hold) begin
            if (r) begin
                m_hold = 0;
                if (md) model_start(p, l);
            end else if (md) begin
                m_ovr = 1;
            end
        end else if (md) begin
            if (!m_in_frame) model_start(p, l);
            else begin
                m_sum = m_sum + p;
                m_taken++;
                if (m_taken == m_target) begin m_hold = 1; m_in_frame = 0; end
            end
        end
    endtask

    // Drive one cycle of inputs, let the DUT sample them, advance the model, settle 1 time unit
    task automatic cycle(input bit c, input bit md, input logic [15:0] p, input logic [3:0] l, input bit r);
        clear = c; mul_done = md; mul_prod = p; len = l; out_ready = r;
        @(posedge clk);
        model_step(c, md, p, l, r);
        #1;
        clear = 0; mul_done = 0; out_ready = 0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
        checks++; if (acc_out !== 20'h0) begin errors++; $display("FAIL reset_acc got=%05h want=00000", acc_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b want=0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%0b want=0", overrun); end
        @(posedge clk); #1;
        reset = 0;
        model_reset();
    endtask

    task automatic test_full_frame();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid got=%0b want=0", out_valid); end
            end
            cycle(0, 1, 16'hFE01, 4'd3, 0);
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid got=%0b want=1", out_valid); end
        checks++; if (acc_out !== 20'h3F804) begin errors++; $display("FAIL full_acc got=%05h want=3F804", acc_out); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy got=%0b want=1", busy); end
        cycle(0, 0, 16'h0, 4'd3, 0);
        checks++; if (acc_out !== 20'h3F804 || out_valid !== 1'b1) begin errors++; $display("FAIL full_stable got=%05h/%0b want=3F804/1", acc_out, out_valid); end
        cycle(0, 0, 16'h0, 4'd3, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_release got=%0b want=0", out_valid); end
    endtask

    task automatic test_single();
        cycle(0, 1, 16'h1234, 4'd0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b want=1", out_valid); end
        checks++; if (acc_out !== 20'h01234) begin errors++; $display("FAIL single_acc got=%05h want=01234", acc_out); end
        cycle(0, 0, 16'h0, 4'd0, 1);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle got=%0b/%0b want=0/0", out_valid, busy); end
    endtask

    task automatic test_max_frame();
        for (int i = 0; i < 16; i++) cycle(0, 1, 16'hFE01, 4'd15, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL max_valid got=%0b want=1", out_valid); end
        checks++; if (acc_out !== 20'hFE010) begin errors++; $display("FAIL max_acc got=%05h want=FE010", acc_out); end
        cycle(0, 0, 16'h0, 4'd15, 1);
    endtask

    task automatic test_overrun();
        cycle(0, 1, 16'h0055, 4'd0, 0);
        cycle(0, 1, 16'h0005, 4'd0, 0);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got=%0b want=1", overrun); end
        checks++; if (acc_out !== 20'h00055) begin errors++; $display("FAIL ovr_acc got=%05h want=00055", acc_out); end
        cycle(1, 1, 16'h0009, 4'd0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got=%0b want=0", out_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL clr_overrun got=%0b want=0", overrun); end
        checks++; if (acc_out !== 20'h0) begin errors++; $display("FAIL clr_acc got=%05h want=00000", acc_out); end
    endtask

    task automatic test_handshake_new();
        cycle(0, 1, 16'h0009, 4'd0, 0);
        cycle(0, 1, 16'h0007, 4'd1, 1);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL hs_accum got=%0b/%0b want=0/0", out_valid, busy); end
        checks++; if (acc_out !== 20'h00007) begin errors++; $display("FAIL hs_acc got=%05h want=00007", acc_out); end
        cycle(0, 1, 16'h0003, 4'd1, 0);
        checks++; if (out_valid !== 1'b1 || acc_out !== 20'd10) begin errors++; $display("FAIL hs_second got=%0b/%05h want=1/0000A", out_valid, acc_out); end
        cycle(0, 0, 16'h0, 4'd1, 1);
    endtask

    task automatic test_reset_mid_and_len();
        cycle(0, 1, 16'h1111, 4'd3, 0);
        cycle(0, 1, 16'h2222, 4'd3, 0);
        #3;
        reset = 1;
        #1;
        checks++; if (acc_out !== 20'h0) begin errors++; $display("FAIL async_acc got=%05h want=00000", acc_out); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL async_flags got=%0b%0b%0b want=000", out_valid, busy, overrun); end
        model_reset();
        @(posedge clk); #1;
        reset = 0;
        cycle(0, 1, 16'h0010, 4'd1, 0);
        cycle(0, 1, 16'h0020, 4'd3, 0);
        checks++; if (out_valid !== 1'b1 || acc_out !== 20'h00030) begin errors++; $display("FAIL len_change got=%0b/%05h want=1/00030", out_valid, acc_out); end
        cycle(0, 0, 16'h0, 4'd3, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 31) == 0), $urandom_range(0, 1), 16'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 1));
            checks++;
            if (out_valid !== m_hold || busy !== m_hold || acc_out !== m_sum[19:0] || overrun !== m_ovr) begin
                errors++;
                $display("FAIL random_%0d got v=%0b b=%0b acc=%05h o=%0b want v=%0b b=%0b acc=%05h o=%0b",
                         i, out_valid, busy, acc_out, overrun, m_hold, m_hold, m_sum[19:0], m_ovr);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_frame();
        test_single();
        test_max_frame();
        test_overrun();
        test_handshake_new();
        test_reset_mid_and_len();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
